// File: rtl/uart_pkg.sv
// Shared state encoding and configuration limits for the UART transceiver.
// The optional parity bit is selected by the UART_PARITY_EN macro in uart_xcvr.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;
  localparam int MIN_STOP_BITS = 1;
  localparam int MAX_STOP_BITS = 2;
  localparam int MIN_DIV       = 4;

  function automatic bit uart_cfg_ok(int data_bits, int stop_bits, int div);
    return (data_bits >= MIN_DATA_BITS) && (data_bits <= MAX_DATA_BITS) &&
           (stop_bits >= MIN_STOP_BITS) && (stop_bits <= MAX_STOP_BITS) &&
           (div >= MIN_DIV);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter running 0..DIV-1; tick marks the last cycle of a bit,
// half_tick marks the mid-bit cycle. restart forces the count back to 0.
module uart_baud_cnt #(
  parameter int DIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic half_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick      = (cnt == LAST);
  assign half_tick = (cnt == HALF);

endmodule

// File: rtl/uart_xcvr.sv
// Single-clock UART transmitter + receiver with independent bit timing.
// Define UART_PARITY_EN to add an even parity bit after the data bits.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam uart_state_t AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_t AFTER_DATA = ST_STOP;
`endif

  if (!uart_cfg_ok(DATA_BITS, STOP_BITS, DIV)) begin : g_cfg_err
    $error("uart_xcvr: illegal DATA_BITS, STOP_BITS or baud divisor");
  end

  // ---------------- transmitter ----------------
  // Handshake: a word is taken on any clk edge where tx_valid && tx_ready.
  uart_state_t          tx_state, tx_state_n;
  logic                 tx_tick, tx_half_unused, tx_accept, tx_last_stop;
  logic [DATA_BITS-1:0] tx_shreg;
  logic [3:0]           tx_bit_idx;
  logic                 tx_stop_idx;
  logic                 tx_par;

  uart_baud_cnt #(.DIV(DIV)) u_tx_cnt (
    .clk       (clk),
    .rst       (rst),
    .restart   (tx_state == ST_IDLE),
    .tick      (tx_tick),
    .half_tick (tx_half_unused)
  );

  // Ready returns in the final stop-bit cycle so a waiting word follows with no gap.
  assign tx_last_stop = (tx_state == ST_STOP) && tx_tick && (tx_stop_idx == LAST_STOP);
  assign tx_ready     = !rst && ((tx_state == ST_IDLE) || tx_last_stop);
  assign tx_accept    = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) tx_state <= ST_IDLE;
    else     tx_state <= tx_state_n;
  end

  always_comb begin
    tx_state_n = tx_state;
    case (tx_state)
      ST_IDLE:   if (tx_accept) tx_state_n = ST_START;
      ST_START:  if (tx_tick) tx_state_n = ST_DATA;
      ST_DATA:   if (tx_tick && (tx_bit_idx == LAST_BIT)) tx_state_n = AFTER_DATA;
      ST_PARITY: if (tx_tick) tx_state_n = ST_STOP;
      ST_STOP:   if (tx_last_stop) tx_state_n = tx_accept ? ST_START : ST_IDLE;
      default:   tx_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shreg    <= '0;
      tx_bit_idx  <= '0;
      tx_stop_idx <= 1'b0;
      tx_par      <= 1'b0;
    end else if (tx_accept) begin
      tx_shreg    <= tx_data;
      tx_par      <= ^tx_data;
      tx_bit_idx  <= '0;
      tx_stop_idx <= 1'b0;
    end else if (tx_tick) begin
      if (tx_state == ST_DATA) begin
        tx_shreg   <= tx_shreg >> 1;
        tx_bit_idx <= tx_bit_idx + 1'b1;
      end
      if (tx_state == ST_STOP) tx_stop_idx <= ~tx_stop_idx;
    end
  end

  always_comb begin
    tx = 1'b1;
    case (tx_state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = tx_shreg[0];
      ST_PARITY: tx = tx_par;
      default:   tx = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  uart_state_t          rx_state, rx_state_n;
  logic                 rx_s1, rx_s2, rx_prev, rx_fall;
  logic                 rx_tick, rx_half;
  logic [3:0]           rx_bit_idx;
  logic [DATA_BITS-1:0] rx_shreg;

  uart_baud_cnt #(.DIV(DIV)) u_rx_cnt (
    .clk       (clk),
    .rst       (rst),
    .restart   ((rx_state == ST_IDLE) || ((rx_state == ST_START) && rx_half)),
    .tick      (rx_tick),
    .half_tick (rx_half)
  );

  assign rx_fall = rx_prev && !rx_s2;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= ST_IDLE;
    else     rx_state <= rx_state_n;
  end

  // The START half-bit sample re-centres the counter, so later ticks land mid-bit.
  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      ST_IDLE:   if (rx_fall) rx_state_n = ST_START;
      ST_START:  if (rx_half) rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
      ST_DATA:   if (rx_tick && (rx_bit_idx == LAST_BIT)) rx_state_n = AFTER_DATA;
      ST_PARITY: if (rx_tick) rx_state_n = ST_STOP;
      ST_STOP:   if (rx_tick) rx_state_n = ST_IDLE;
      default:   rx_state_n = ST_IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  logic rx_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_par     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if ((rx_state == ST_PARITY) && rx_tick) rx_par <= rx_s2;
      if ((rx_state == ST_STOP) && rx_tick) parity_err <= rx_par ^ (^rx_shreg);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_bit_idx <= '0;
      rx_shreg   <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      if (rx_state == ST_START) rx_bit_idx <= '0;
      if ((rx_state == ST_DATA) && rx_tick) begin
        rx_shreg   <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
        rx_bit_idx <= rx_bit_idx + 1'b1;
      end
      if ((rx_state == ST_STOP) && rx_tick) begin
        rx_data   <= rx_shreg;
        rx_valid  <= 1'b1;
        frame_err <= !rx_s2;
      end
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// Self-checking bench for uart_xcvr: TX waveform, loopback, false start,
// framing/parity errors and mid-frame reset. Honours UART_PARITY_EN.
module tb_uart_xcvr;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 9600;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int DIV       = CLK_FREQ / BAUD_RATE;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int FRAME_CYC  = FRAME_BITS * DIV;
  localparam int W          = DATA_BITS + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 tx_valid = 1'b0;
  logic [DATA_BITS-1:0] tx_data  = '0;
  logic                 tx_ready, tx;
  logic                 rx_drv   = 1'b1;
  logic                 loop_en  = 1'b0;
  logic                 rx_line;
  logic                 rx_valid, frame_err, parity_err;
  logic [DATA_BITS-1:0] rx_data;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_xcvr #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .rx         (rx_line),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic         mid_bits [0:15];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      check("rx_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e[DATA_BITS-1:0]));
        check("frame_err", 32'(frame_err), 32'(e[DATA_BITS]));
        check("parity_err", 32'(parity_err), 32'(e[DATA_BITS+1]));
      end
    end
  end

  // Frame bit i (0 = start); bits beyond the first stop bit are idle-high.
  function automatic logic [15:0] frame_bits(input logic [DATA_BITS-1:0] d,
                                             input logic par_flip, input logic stop0);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
    k = 1 + DATA_BITS;
    if (PAR_BITS == 1) begin
      f[k] = (^d) ^ par_flip;
      k++;
    end
    f[k] = stop0;
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 4 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, 32'(tx_ready), 1);
  endtask

  task automatic send_word(input logic [DATA_BITS-1:0] d);
    wait_ready("send");
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic send_and_check(input logic [DATA_BITS-1:0] d, input string tag);
    logic [15:0] f;
    int bad, rbad, b;
    f = frame_bits(d, 1'b0, 1'b1);
    bad = 0;
    rbad = 0;
    wait_ready(tag);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int cyc = 1; cyc <= FRAME_CYC; cyc++) begin
      b = (cyc - 1) / DIV;
      if (tx !== f[b]) bad++;
      if ((cyc - 1) % DIV == DIV / 2) mid_bits[b] = tx;
      if (tx_ready !== (cyc == FRAME_CYC)) rbad++;
      // A request while busy must be dropped, not queued.
      if (cyc == 300) begin
        tx_data  = ~d;
        tx_valid = 1'b1;
      end
      if (cyc == 301) tx_valid = 1'b0;
      if (cyc < FRAME_CYC) @(negedge clk);
    end
    check({tag, "_wave"}, bad, 0);
    check({tag, "_ready_low"}, rbad, 0);
    @(negedge clk);
    check({tag, "_idle_tx"}, 32'(tx), 1);
    check({tag, "_idle_ready"}, 32'(tx_ready), 1);
  endtask

  task automatic drive_rx_frame(input logic [DATA_BITS-1:0] d, input logic par_flip,
                                input logic stop0);
    logic [15:0] f;
    logic perr;
    f = frame_bits(d, par_flip, stop0);
    perr = (PAR_BITS == 1) ? par_flip : 1'b0;
    exp_q.push_back({perr, !stop0, d});
    for (int b = 0; b < FRAME_BITS; b++) begin
      rx_drv = f[b];
      repeat (DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    repeat (DIV) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c0;
    logic [DATA_BITS-1:0] got;
    logic [DATA_BITS-1:0] words [4];
    words = '{8'h00, 8'hFF, 8'hA5, 8'h5A};

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(tx_ready), 1);

    // Transmit waveform for 0x40
    send_and_check(8'h40, "tx40");
    for (int i = 0; i < DATA_BITS; i++) got[i] = mid_bits[1+i];
    check("tx40_bits", 32'(got), 32'h40);
    check("tx40_start", 32'(mid_bits[0]), 0);
    check("tx40_stop", 32'(mid_bits[FRAME_BITS-1]), 1);

    // Loopback, back-to-back words
    loop_en = 1'b1;
    c0 = rx_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'b00, words[i]});
      send_word(words[i]);
    end
    wait_drain("loop");
    check("loop_count", rx_cnt - c0, 4);
    loop_en = 1'b0;

    // False start: 30-cycle low pulse
    c0 = rx_cnt;
    rx_drv = 1'b0;
    repeat (10) @(negedge clk);
    check("fs_in_start", 32'(dut.rx_state), 32'(ST_START));
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("fs_no_valid", rx_cnt - c0, 0);
    check("fs_idle", 32'(dut.rx_state), 32'(ST_IDLE));
    check("fs_data_held", 32'(rx_data), 32'h5A);

    // Framing error then recovery
    drive_rx_frame(8'h31, 1'b0, 1'b0);
    wait_drain("ferr");
    repeat (300) @(negedge clk);
    check("ferr_held", 32'(frame_err), 1);
    check("ferr_data_held", 32'(rx_data), 32'h31);
    drive_rx_frame(8'h32, 1'b0, 1'b1);
    wait_drain("ferr_clear");
    check("ferr_cleared", 32'(frame_err), 0);

`ifdef UART_PARITY_EN
    send_and_check(8'h07, "tx07");
    check("tx07_parity", 32'(mid_bits[1+DATA_BITS]), 1);
    drive_rx_frame(8'h55, 1'b1, 1'b1);
    wait_drain("perr");
    check("perr_held", 32'(parity_err), 1);
    drive_rx_frame(8'h55, 1'b0, 1'b1);
    wait_drain("perr_clear");
    check("perr_cleared", 32'(parity_err), 0);
`endif

    // Reset 500 cycles into a frame, with RX following the line
    loop_en = 1'b1;
    c0 = rx_cnt;
    send_word(8'h55);
    repeat (499) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 1);
    check("mid_rst_ready", 32'(tx_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_release_ready", 32'(tx_ready), 1);
    check("mid_rst_rx_data", 32'(rx_data), 0);
    check("mid_rst_frame_err", 32'(frame_err), 0);
    exp_q.push_back({2'b00, 8'h3C});
    send_and_check(8'h3C, "tx3c");
    wait_drain("mid_rst");
    check("mid_rst_rx_count", rx_cnt - c0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
